// File: rtl/mfm_pkg.sv
// Shared constants and FSM state type for the MFM read-path front end.
// Pure definitions: no logic, no latency, no flow control.
package mfm_pkg;

    localparam int          CELL_CLKS_DEF = 5;
    localparam logic [15:0] MARK_A1       = 16'h4489;

    typedef enum logic [1:0] {
        HUNT_GAP  = 2'd0,
        HUNT_MARK = 2'd1,
        SYNCED    = 2'd2
    } scan_state_t;

endpackage

// File: rtl/mfm_cell_sampler.sv
// Synchronises rd_data_n, detects falling edges and recovers MFM cell timing.
// cell_done/cell_bit registered, 2 clocks after the centring pulse; free-running, no backpressure.
module mfm_cell_sampler
    import mfm_pkg::*;
#(
    parameter int CELL_CLKS = CELL_CLKS_DEF
) (
    input  logic clk_50,
    input  logic reset,
    input  logic i_rd_data_n,
    output logic o_cell_done,
    output logic o_cell_bit
);

    localparam int            PW      = $clog2(CELL_CLKS);
    localparam logic [PW-1:0] PH_LAST = PW'(CELL_CLKS - 1);
    localparam logic [PW-1:0] PH_MID  = PW'(CELL_CLKS / 2);

    logic          r_meta;
    logic          r_sync;
    logic          r_sync_d;
    logic          r_pulse;
    logic          r_cell_hit;
    logic [PW-1:0] r_phase;
    logic          r_cell_done;
    logic          r_cell_bit;
    logic          w_wrap;

    assign w_wrap      = (r_phase == PH_LAST);
    assign o_cell_done = r_cell_done;
    assign o_cell_bit  = r_cell_bit;

    always_ff @(posedge clk_50) begin
        if (!reset) begin
            r_meta      <= 1'b0;
            r_sync      <= 1'b0;
            r_sync_d    <= 1'b0;
            r_pulse     <= 1'b0;
            r_cell_hit  <= 1'b0;
            r_phase     <= '0;
            r_cell_done <= 1'b0;
            r_cell_bit  <= 1'b0;
        end else begin
            r_meta   <= i_rd_data_n;
            r_sync   <= r_meta;
            r_sync_d <= r_sync;
            r_pulse  <= r_sync_d & ~r_sync;

            // A pulse landing on the wrap cycle belongs to the next cell; the
            // completing cell still reports the old hit.
            if (r_pulse)
                r_phase <= PH_MID;
            else if (w_wrap)
                r_phase <= '0;
            else
                r_phase <= r_phase + PW'(1);

            if (r_pulse)
                r_cell_hit <= 1'b1;
            else if (w_wrap)
                r_cell_hit <= 1'b0;

            r_cell_done <= w_wrap;
            r_cell_bit  <= r_cell_hit;
        end
    end

endmodule

// File: rtl/mfm_gap_scanner.sv
// Hunts preamble gap + A1 mark in the MFM cell stream, then deserialises sector bytes.
// Registered outputs; one byte per 16 cells (nominal 80 clocks); no backpressure, downstream samples on strobe.
module mfm_gap_scanner
    import mfm_pkg::*;
#(
    parameter int          CELL_CLKS    = CELL_CLKS_DEF,
    parameter int          GAP_BYTES    = 8,
    parameter logic [15:0] SECTOR_BYTES = 16'd512,
    parameter logic [15:0] MARK_PATTERN = MARK_A1
) (
    input  logic       clk_50,
    input  logic       reset,
    input  logic       rd_data_n,
    output logic       sync,
    output logic [7:0] byte_buffer,
    output logic       byte_strobe,
    output logic       cell_err
);

    localparam int         GAP_CELLS  = (GAP_BYTES * 16 > 255) ? 255 : GAP_BYTES * 16;
    localparam logic [7:0] GAP_TARGET = 8'(GAP_CELLS);

    logic        w_cell_done;
    logic        w_cell_bit;

    scan_state_t r_state;
    scan_state_t w_state_next;
    logic [15:0] r_sr;
    logic [7:0]  r_gap_cnt;
    logic [3:0]  r_cell_cnt;
    logic [15:0] r_byte_cnt;
    logic        r_sync_o;
    logic [7:0]  r_byte;
    logic        r_strobe;
    logic        r_err;
    logic        r_sector_end;

    logic [15:0] w_sr_next;
    logic [7:0]  w_byte_next;
    logic [7:0]  w_gap_inc;
    logic [15:0] w_byte_cnt_inc;
    logic        w_viol;
    logic        w_alt;
    logic        w_byte_last;
    logic        w_gap_clr;
    logic        w_gap_step;
    logic        w_sync_clr;
    logic        w_load;
    logic        w_enter_sync;

    mfm_cell_sampler #(
        .CELL_CLKS (CELL_CLKS)
    ) u_sampler (
        .clk_50      (clk_50),
        .reset       (reset),
        .i_rd_data_n (rd_data_n),
        .o_cell_done (w_cell_done),
        .o_cell_bit  (w_cell_bit)
    );

    assign w_sr_next      = {r_sr[14:0], w_cell_bit};
    assign w_viol         = w_cell_done && ((w_sr_next[1:0] == 2'b11) || (w_sr_next[3:0] == 4'b0000));
    assign w_alt          = (w_cell_bit != r_sr[0]);
    assign w_gap_inc      = (r_gap_cnt == 8'hFF) ? r_gap_cnt : r_gap_cnt + 8'd1;
    assign w_byte_last    = w_cell_done && (r_cell_cnt == 4'd15);
    assign w_byte_cnt_inc = r_byte_cnt + 16'd1;

    // Data cells sit on the even shift-register positions; newest bit is the LSB.
    always_comb begin
        w_byte_next = '0;
        for (int i = 0; i < 8; i++)
            w_byte_next[i] = w_sr_next[2*i];
    end

    always_comb begin
        w_state_next = r_state;
        w_gap_clr    = 1'b0;
        w_gap_step   = 1'b0;
        w_sync_clr   = 1'b0;
        w_load       = 1'b0;
        w_enter_sync = 1'b0;
        case (r_state)
            HUNT_GAP: begin
                if (w_cell_done) begin
                    if (w_alt) begin
                        w_gap_step = 1'b1;
                        if (w_gap_inc >= GAP_TARGET)
                            w_state_next = HUNT_MARK;
                    end else begin
                        w_gap_clr = 1'b1;
                    end
                end
            end
            HUNT_MARK: begin
                if (w_cell_done) begin
                    if (w_sr_next == MARK_PATTERN) begin
                        w_state_next = SYNCED;
                        w_enter_sync = 1'b1;
                    end else if (w_viol) begin
                        w_state_next = HUNT_GAP;
                        w_gap_clr    = 1'b1;
                    end
                end
            end
            SYNCED: begin
                if (w_viol) begin
                    w_state_next = HUNT_GAP;
                    w_gap_clr    = 1'b1;
                    w_sync_clr   = 1'b1;
                end else if (w_byte_last) begin
                    w_load = 1'b1;
                    if (w_byte_cnt_inc == SECTOR_BYTES) begin
                        w_state_next = HUNT_GAP;
                        w_gap_clr    = 1'b1;
                    end
                end
            end
            default: begin
                w_state_next = HUNT_GAP;
                w_gap_clr    = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk_50) begin
        if (!reset) begin
            r_state      <= HUNT_GAP;
            r_sr         <= '0;
            r_gap_cnt    <= '0;
            r_cell_cnt   <= '0;
            r_byte_cnt   <= '0;
            r_sync_o     <= 1'b0;
            r_byte       <= '0;
            r_strobe     <= 1'b0;
            r_err        <= 1'b0;
            r_sector_end <= 1'b0;
        end else begin
            r_state  <= w_state_next;
            r_strobe <= w_load;
            r_err    <= w_viol;

            if (w_cell_done)
                r_sr <= w_sr_next;

            if (w_gap_clr)
                r_gap_cnt <= '0;
            else if (w_gap_step)
                r_gap_cnt <= w_gap_inc;

            if (w_enter_sync)
                r_cell_cnt <= '0;
            else if ((r_state == SYNCED) && w_cell_done)
                r_cell_cnt <= r_cell_cnt + 4'd1;

            if (w_enter_sync)
                r_byte_cnt <= '0;
            else if (w_load)
                r_byte_cnt <= w_byte_cnt_inc;

            if (w_load)
                r_byte <= w_byte_next;

            // sync stays up for one cycle past the final byte so the last
            // strobe is still qualified downstream.
            r_sector_end <= w_load && (w_byte_cnt_inc == SECTOR_BYTES);
            if (w_sync_clr || r_sector_end)
                r_sync_o <= 1'b0;
            else if (w_load)
                r_sync_o <= 1'b1;
        end
    end

    assign sync        = r_sync_o;
    assign byte_buffer = r_byte;
    assign byte_strobe = r_strobe;
    assign cell_err    = r_err;

endmodule

// File: tb/tb_mfm_gap_scanner.sv
// Randomised frame-level bench for mfm_gap_scanner; expected bytes come from an MFM encoder model.
module tb_mfm_gap_scanner;
    import mfm_pkg::*;

    localparam int          CELL = 5;
    localparam logic [15:0] SECT = 16'd4;

    logic       clk_50    = 1'b0;
    logic       reset     = 1'b0;
    logic       rd_data_n = 1'b1;
    logic       sync;
    logic [7:0] byte_buffer;
    logic       byte_strobe;
    logic       cell_err;

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;

    mfm_gap_scanner #(
        .CELL_CLKS    (CELL),
        .GAP_BYTES    (8),
        .SECTOR_BYTES (SECT),
        .MARK_PATTERN (16'h4489)
    ) dut (
        .clk_50      (clk_50),
        .reset       (reset),
        .rd_data_n   (rd_data_n),
        .sync        (sync),
        .byte_buffer (byte_buffer),
        .byte_strobe (byte_strobe),
        .cell_err    (cell_err)
    );

    always #10 clk_50 = ~clk_50;
    always @(posedge clk_50) cyc <= cyc + 1;

    // Output event log, sampled mid-cycle.
    int         stb_cyc[$];
    logic [7:0] stb_val[$];
    logic       stb_sync[$];
    logic       stb_prev[$];
    int         err_cyc[$];
    logic       err_sync[$];
    logic       err_prev[$];
    int         fall_cyc[$];
    logic       prev_sync = 1'b0;

    always @(negedge clk_50) begin
        if (byte_strobe === 1'b1) begin
            stb_cyc.push_back(cyc);
            stb_val.push_back(byte_buffer);
            stb_sync.push_back(sync);
            stb_prev.push_back(prev_sync);
        end
        if (cell_err === 1'b1) begin
            err_cyc.push_back(cyc);
            err_sync.push_back(sync);
            err_prev.push_back(prev_sync);
        end
        if (prev_sync === 1'b1 && sync === 1'b0)
            fall_cyc.push_back(cyc);
        prev_sync = sync;
    end

    task automatic clear_mon();
        stb_cyc.delete(); stb_val.delete(); stb_sync.delete(); stb_prev.delete();
        err_cyc.delete(); err_sync.delete(); err_prev.delete(); fall_cyc.delete();
    endtask

    // Reference encoder: bytes -> MFM cell list.
    logic       cells[$];
    logic       last_d;
    logic [7:0] exp_q[$];

    task automatic add_zeros(input int n);
        for (int i = 0; i < n; i++) cells.push_back(1'b0);
        last_d = 1'b0;
    endtask

    task automatic add_byte(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) begin
            cells.push_back(~(last_d | b[i]));
            cells.push_back(b[i]);
            last_d = b[i];
        end
    endtask

    task automatic add_mark();
        logic [15:0] m;
        m = 16'h4489;
        for (int i = 15; i >= 0; i--) cells.push_back(m[i]);
        last_d = 1'b1;
    endtask

    task automatic rand_data(input int n);
        for (int i = 0; i < n; i++) exp_q.push_back(8'($urandom_range(0, 255)));
    endtask

    task automatic build_frame(input int pre);
        cells.delete();
        add_zeros(12);
        for (int i = 0; i < pre; i++) add_byte(8'h00);
        add_mark();
        foreach (exp_q[i]) add_byte(exp_q[i]);
        add_zeros(12);
    endtask

    // Each 1-cell becomes a 2-clock low pulse; with jitter, pulses are placed
    // relative to the previous one with a +-1 clock error.
    task automatic send_cells(input bit jitter);
        int pulses[$];
        int last_t, last_i, t, tend, p;
        last_t = -1; last_i = 0; p = 0;
        for (int i = 0; i < cells.size(); i++) begin
            if (cells[i]) begin
                if (!jitter || last_t < 0) t = CELL * i + 1;
                else t = last_t + CELL * (i - last_i) + int'($urandom_range(0, 2)) - 1;
                pulses.push_back(t); last_t = t; last_i = i;
            end
        end
        tend = CELL * cells.size();
        if (last_t >= 0 && last_t + CELL * (cells.size() - last_i) > tend)
            tend = last_t + CELL * (cells.size() - last_i);
        tend += 4;
        for (int c = 0; c < tend; c++) begin
            @(posedge clk_50); #1;
            rd_data_n = 1'b1;
            if (p < pulses.size() && c >= pulses[p]) begin
                rd_data_n = 1'b0;
                if (c >= pulses[p] + 1) p++;
            end
        end
        rd_data_n = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        clear_mon();
        for (int c = 0; c < 60; c++) begin
            @(posedge clk_50); #1;
            rd_data_n = ((c % 7) < 2) ? 1'b0 : 1'b1;
        end
        rd_data_n = 1'b1;
        @(negedge clk_50);
        n_checks++; if (sync !== 1'b0) begin n_errors++; $display("FAIL reset_sync: got %b want 0", sync); end
        n_checks++; if (byte_buffer !== 8'h00) begin n_errors++; $display("FAIL reset_byte: got %h want 00", byte_buffer); end
        n_checks++; if (stb_cyc.size() != 0) begin n_errors++; $display("FAIL reset_strobes: got %0d want 0", stb_cyc.size()); end
        n_checks++; if (err_cyc.size() != 0) begin n_errors++; $display("FAIL reset_cell_err: got %0d want 0", err_cyc.size()); end
        @(posedge clk_50); #1; reset = 1'b1;
        @(negedge clk_50);
        n_checks++; if (dut.r_state !== HUNT_GAP) begin n_errors++; $display("FAIL reset_state: got %0d want %0d", dut.r_state, HUNT_GAP); end
    endtask

    task automatic test_first_byte();
        exp_q.delete(); exp_q.push_back(8'hFE); rand_data(3);
        build_frame(8); clear_mon(); send_cells(1'b0);
        n_checks++; if (stb_cyc.size() != 4) begin n_errors++; $display("FAIL first_count: got %0d want 4", stb_cyc.size()); end
        if (stb_cyc.size() >= 2) begin
            n_checks++; if (stb_val[0] !== 8'hFE) begin n_errors++; $display("FAIL first_byte: got %h want fe", stb_val[0]); end
            n_checks++; if (stb_sync[0] !== 1'b1 || stb_prev[0] !== 1'b0) begin n_errors++; $display("FAIL first_sync_edge: sync %b prev %b want 1/0", stb_sync[0], stb_prev[0]); end
            n_checks++; if (stb_cyc[1] - stb_cyc[0] < 78 || stb_cyc[1] - stb_cyc[0] > 82) begin n_errors++; $display("FAIL first_spacing: got %0d want 80+-2", stb_cyc[1] - stb_cyc[0]); end
        end
        for (int k = 1; k < stb_val.size() && k < exp_q.size(); k++) begin
            n_checks++; if (stb_val[k] !== exp_q[k]) begin n_errors++; $display("FAIL first_data[%0d]: got %h want %h", k, stb_val[k], exp_q[k]); end
        end
    endtask

    task automatic test_sector_end();
        exp_q.delete();
        for (int i = 1; i <= 4; i++) exp_q.push_back(8'(i));
        build_frame(8); clear_mon(); send_cells(1'b0);
        n_checks++; if (stb_cyc.size() != 4) begin n_errors++; $display("FAIL sector_count: got %0d want 4", stb_cyc.size()); end
        for (int k = 0; k < stb_val.size() && k < exp_q.size(); k++) begin
            n_checks++; if (stb_val[k] !== exp_q[k]) begin n_errors++; $display("FAIL sector_data[%0d]: got %h want %h", k, stb_val[k], exp_q[k]); end
        end
        if (stb_cyc.size() == 4) begin
            n_checks++; if (stb_sync[3] !== 1'b1) begin n_errors++; $display("FAIL sector_last_sync: got %b want 1", stb_sync[3]); end
            n_checks++; if (fall_cyc.size() != 1 || fall_cyc[0] != stb_cyc[3] + 1) begin n_errors++; $display("FAIL sector_sync_fall: got %0d falls first at %0d want 1 at %0d", fall_cyc.size(), (fall_cyc.size() > 0) ? fall_cyc[0] : -1, stb_cyc[3] + 1); end
        end
        n_checks++; if (sync !== 1'b0) begin n_errors++; $display("FAIL sector_idle_sync: got %b want 0", sync); end
    endtask

    task automatic test_short_preamble();
        exp_q.delete(); rand_data(4);
        build_frame(6); clear_mon(); send_cells(1'b0);
        n_checks++; if (stb_cyc.size() != 0 || fall_cyc.size() != 0) begin n_errors++; $display("FAIL short_gap_nosync: got %0d strobes %0d sync falls want 0/0", stb_cyc.size(), fall_cyc.size()); end
        exp_q.delete(); rand_data(4);
        build_frame(8); clear_mon(); send_cells(1'b0);
        n_checks++; if (stb_cyc.size() != 4) begin n_errors++; $display("FAIL retry_count: got %0d want 4", stb_cyc.size()); end
        for (int k = 0; k < stb_val.size() && k < exp_q.size(); k++) begin
            n_checks++; if (stb_val[k] !== exp_q[k]) begin n_errors++; $display("FAIL retry_data[%0d]: got %h want %h", k, stb_val[k], exp_q[k]); end
        end
    endtask

    task automatic test_cell_error();
        int ei;
        exp_q.delete();
        cells.delete();
        add_zeros(12);
        for (int i = 0; i < 8; i++) add_byte(8'h00);
        add_mark(); add_byte(8'h11); add_byte(8'h22);
        add_zeros(4);
        add_byte(8'h33); add_byte(8'h44); add_zeros(12);
        clear_mon(); send_cells(1'b0);
        n_checks++; if (stb_cyc.size() != 2) begin n_errors++; $display("FAIL err_strobes: got %0d want 2", stb_cyc.size()); end
        if (stb_cyc.size() >= 2) begin
            n_checks++; if (stb_val[0] !== 8'h11 || stb_val[1] !== 8'h22) begin n_errors++; $display("FAIL err_data: got %h %h want 11 22", stb_val[0], stb_val[1]); end
        end
        ei = -1;
        foreach (err_cyc[i]) if (ei < 0 && stb_cyc.size() >= 2 && err_cyc[i] > stb_cyc[1]) ei = i;
        n_checks++;
        if (ei < 0) begin
            n_errors++; $display("FAIL err_pulse: got none want cell_err after byte 2");
        end else if (err_sync[ei] !== 1'b0 || err_prev[ei] !== 1'b1 || fall_cyc.size() == 0 || fall_cyc[0] != err_cyc[ei]) begin
            n_errors++; $display("FAIL err_sync_drop: sync %b prev %b falls %0d want sync 0 prev 1 fall at %0d", err_sync[ei], err_prev[ei], fall_cyc.size(), err_cyc[ei]);
        end
        n_checks++; if (byte_buffer !== 8'h22) begin n_errors++; $display("FAIL err_hold_byte: got %h want 22", byte_buffer); end
        exp_q.delete(); rand_data(4);
        build_frame(8); clear_mon(); send_cells(1'b0);
        n_checks++; if (stb_cyc.size() != 4) begin n_errors++; $display("FAIL rescan_count: got %0d want 4", stb_cyc.size()); end
        for (int k = 0; k < stb_val.size() && k < exp_q.size(); k++) begin
            n_checks++; if (stb_val[k] !== exp_q[k]) begin n_errors++; $display("FAIL rescan_data[%0d]: got %h want %h", k, stb_val[k], exp_q[k]); end
        end
    endtask

    task automatic test_jitter();
        int nerr;
        for (int f = 0; f < 3; f++) begin
            exp_q.delete(); rand_data(4);
            build_frame(8); clear_mon(); send_cells(1'b1);
            n_checks++; if (stb_cyc.size() != 4) begin n_errors++; $display("FAIL jitter_count[%0d]: got %0d want 4", f, stb_cyc.size()); end
            for (int k = 0; k < stb_val.size() && k < exp_q.size(); k++) begin
                n_checks++; if (stb_val[k] !== exp_q[k]) begin n_errors++; $display("FAIL jitter_data[%0d][%0d]: got %h want %h", f, k, stb_val[k], exp_q[k]); end
            end
            if (stb_cyc.size() > 0) begin
                nerr = 0;
                foreach (err_cyc[i]) if (err_cyc[i] > stb_cyc[0] - 70 && err_cyc[i] <= stb_cyc[stb_cyc.size() - 1]) nerr++;
                n_checks++; if (nerr != 0) begin n_errors++; $display("FAIL jitter_cell_err[%0d]: got %0d want 0", f, nerr); end
            end
        end
    endtask

    task automatic test_reset_mid_sector();
        int w;
        exp_q.delete(); rand_data(4);
        build_frame(8); clear_mon();
        fork
            send_cells(1'b0);
            begin
                w = 0;
                while (stb_cyc.size() < 2 && w < 4000) begin @(negedge clk_50); w++; end
                n_checks++; if (stb_cyc.size() < 2) begin n_errors++; $display("FAIL midreset_wait: got %0d strobes want 2 before timeout", stb_cyc.size()); end
                @(posedge clk_50); #1; reset = 1'b0;
                repeat (3) @(posedge clk_50);
                @(negedge clk_50);
                n_checks++; if (sync !== 1'b0 || byte_buffer !== 8'h00) begin n_errors++; $display("FAIL midreset_outputs: sync %b byte %h want 0 00", sync, byte_buffer); end
                @(posedge clk_50); #1; reset = 1'b1;
            end
        join
        n_checks++; if (stb_cyc.size() != 2) begin n_errors++; $display("FAIL midreset_no_more: got %0d strobes want 2", stb_cyc.size()); end
        if (stb_cyc.size() >= 2) begin
            n_checks++; if (stb_val[0] !== exp_q[0] || stb_val[1] !== exp_q[1]) begin n_errors++; $display("FAIL midreset_data: got %h %h want %h %h", stb_val[0], stb_val[1], exp_q[0], exp_q[1]); end
        end
    endtask

    initial begin
        #4000000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_first_byte();
        test_sector_end();
        test_short_preamble();
        test_cell_error();
        test_jitter();
        test_reset_mid_sector();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
